alu_mul_sequencer: RTL and testbench

//  Multi-cycle 32x32->64 multiplier controller that reuses the shared 32-bit ALU as its adder.

---
 rtl/alu_mul_sequencer_pkg.sv | 27 ++
 rtl/alu_mul_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_alu_mul_sequencer.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/alu_mul_sequencer_pkg.sv
// Shared encodings for the shift-add multiply sequencer that borrows the execute-stage ALU.
// ALU opcodes match the 2-bit ALU_Control field; FLAG_C_IDX selects C out of {N,Z,C,V}.
package alu_mul_sequencer_pkg;

    localparam logic [1:0] ALU_ADD    = 2'b00;
    localparam logic [1:0] ALU_SUB    = 2'b01;
    localparam int         FLAG_C_IDX = 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_NEG_A  = 3'd1;
    localparam logic [2:0] S_NEG_B  = 3'd2;
    localparam logic [2:0] S_ITER   = 3'd3;
    localparam logic [2:0] S_FIX_LO = 3'd4;
    localparam logic [2:0] S_FIX_HI = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;

    typedef enum logic [2:0] {
        ST_IDLE   = S_IDLE,
        ST_NEG_A  = S_NEG_A,
        ST_NEG_B  = S_NEG_B,
        ST_ITER   = S_ITER,
        ST_FIX_LO = S_FIX_LO,
        ST_FIX_HI = S_FIX_HI,
        ST_DONE   = S_DONE
    } mul_state_t;

endpackage

// File: rtl/alu_mul_sequencer.sv
// 32x32->64 shift-add multiplier controller using the shared external ALU as its adder.
// Signed operands are made magnitude first, and the product is negated at the end when needed.
module alu_mul_sequencer
    import alu_mul_sequencer_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter bit EARLY_TERM = 1'b0
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             Start,
    input  logic             MCycleSigned,
    input  logic [WIDTH-1:0] Operand1,
    input  logic [WIDTH-1:0] Operand2,
    output logic [WIDTH-1:0] Result1,
    output logic [WIDTH-1:0] Result2,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] ALU_SrcA,
    output logic [WIDTH-1:0] ALU_SrcB,
    output logic [1:0]       ALU_Control,
    output logic             ALU_isADC,
    output logic             ALU_CFlag,
    output logic             ALU_isArith,
    input  logic [WIDTH-1:0] ALUResult_in,
    input  logic [3:0]       ALUFlags_in
);

    localparam logic [5:0] CNT_LAST = 6'(WIDTH - 1);
    localparam logic [5:0] CNT_FULL = 6'(WIDTH);

    mul_state_t         r_state;
    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_acc_hi;
    logic [WIDTH-1:0]   r_acc_lo;
    logic [5:0]         r_cnt;
    logic               r_neg_res;
    logic               r_cfix;

    logic               w_carry;
    logic [WIDTH-1:0]   w_sum;
    logic [2*WIDTH-1:0] w_shift;
    logic [5:0]         w_done_iters;
    logic [5:0]         w_tail;
    logic [WIDTH-1:0]   w_rem_mask;
    logic               w_rem_zero;
    logic               w_early;
    logic               w_iter_last;
    logic [2*WIDTH-1:0] w_prod_nxt;
    logic               w_unused_flags;

    assign w_unused_flags = ^{ALUFlags_in[3:2], ALUFlags_in[0]};

    // One iteration; with early termination, the remaining all-zero multiplier bits only
    // contribute shifts, so they are folded in as one wide shift.
    always_comb begin
        w_sum        = r_acc_lo[0] ? ALUResult_in : r_acc_hi;
        w_carry      = r_acc_lo[0] & ALUFlags_in[FLAG_C_IDX];
        w_shift      = {w_carry, w_sum, r_acc_lo[WIDTH-1:1]};
        w_done_iters = r_cnt + 6'd1;
        w_tail       = CNT_FULL - w_done_iters;
        w_rem_mask   = {WIDTH{1'b1}} >> w_done_iters;
        w_rem_zero   = (w_shift[WIDTH-1:0] & w_rem_mask) == '0;
        w_early      = EARLY_TERM && w_rem_zero && (r_cnt != CNT_LAST);
        w_iter_last  = (r_cnt == CNT_LAST) || w_early;
        w_prod_nxt   = w_early ? (w_shift >> w_tail) : w_shift;
    end

    always_comb begin
        ALU_SrcA    = '0;
        ALU_SrcB    = '0;
        ALU_Control = ALU_ADD;
        ALU_isADC   = 1'b0;
        ALU_CFlag   = 1'b0;
        ALU_isArith = 1'b0;
        unique case (r_state)
            ST_IDLE: ;
            ST_NEG_A: begin
                ALU_SrcB    = r_mcand;
                ALU_Control = ALU_SUB;
                ALU_isArith = 1'b1;
            end
            ST_NEG_B, ST_FIX_LO: begin
                ALU_SrcB    = r_acc_lo;
                ALU_Control = ALU_SUB;
                ALU_isArith = 1'b1;
            end
            ST_ITER: begin
                ALU_SrcA    = r_acc_hi;
                ALU_SrcB    = r_mcand;
                ALU_isArith = 1'b1;
            end
            // High word of a 64-bit negate: ~hi plus the borrow-carry from the low word.
            ST_FIX_HI: begin
                ALU_SrcB    = ~r_acc_hi;
                ALU_isADC   = 1'b1;
                ALU_CFlag   = r_cfix;
                ALU_isArith = 1'b1;
            end
            ST_DONE: ALU_isArith = 1'b1;
            default: ;
        endcase
    end

    // Results are loaded on entry to DONE so they are valid during the Done pulse.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state   <= ST_IDLE;
            r_mcand   <= '0;
            r_acc_hi  <= '0;
            r_acc_lo  <= '0;
            r_cnt     <= '0;
            r_neg_res <= 1'b0;
            r_cfix    <= 1'b0;
            Result1   <= '0;
            Result2   <= '0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
        end else begin
            Done <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (Start) begin
                        r_mcand   <= Operand1;
                        r_acc_lo  <= Operand2;
                        r_acc_hi  <= '0;
                        r_cnt     <= '0;
                        r_cfix    <= 1'b0;
                        r_neg_res <= MCycleSigned & (Operand1[WIDTH-1] ^ Operand2[WIDTH-1]);
                        Busy      <= 1'b1;
                        r_state   <= MCycleSigned ? ST_NEG_A : ST_ITER;
                    end
                end
                ST_NEG_A: begin
                    if (r_mcand[WIDTH-1]) begin
                        r_mcand <= ALUResult_in;
                    end
                    r_state <= ST_NEG_B;
                end
                ST_NEG_B: begin
                    if (r_acc_lo[WIDTH-1]) begin
                        r_acc_lo <= ALUResult_in;
                    end
                    r_state <= ST_ITER;
                end
                ST_ITER: begin
                    {r_acc_hi, r_acc_lo} <= w_prod_nxt;
                    r_cnt                <= w_done_iters;
                    if (w_iter_last) begin
                        if (r_neg_res) begin
                            r_state <= ST_FIX_LO;
                        end else begin
                            Result1 <= w_prod_nxt[WIDTH-1:0];
                            Result2 <= w_prod_nxt[2*WIDTH-1:WIDTH];
                            Done    <= 1'b1;
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_FIX_LO: begin
                    r_acc_lo <= ALUResult_in;
                    r_cfix   <= ALUFlags_in[FLAG_C_IDX];
                    r_state  <= ST_FIX_HI;
                end
                ST_FIX_HI: begin
                    r_acc_hi <= ALUResult_in;
                    Result1  <= r_acc_lo;
                    Result2  <= ALUResult_in;
                    Done     <= 1'b1;
                    r_state  <= ST_DONE;
                end
                ST_DONE: begin
                    Busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Directed bench: two sequencers (full-length and early-terminating) each wired to a behavioural ALU.
module tb_alu_mul_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start0 = 1'b0;
    logic        start1 = 1'b0;
    logic        sgn = 1'b0;
    logic [31:0] op1 = '0;
    logic [31:0] op2 = '0;

    logic [31:0] r1_0, r2_0, srca_0, srcb_0, alur_0;
    logic [31:0] r1_1, r2_1, srca_1, srcb_1, alur_1;
    logic [1:0]  ctl_0, ctl_1;
    logic [3:0]  flags_0, flags_1;
    logic        busy_0, done_0, adc_0, cf_0, arith_0;
    logic        busy_1, done_1, adc_1, cf_1, arith_1;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    function automatic logic [35:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                          input logic [1:0] ctl, input logic adc, input logic cf);
        logic [32:0] s;
        logic [31:0] be;
        logic        cin;
        logic        v;
        be  = (ctl == 2'b01) ? ~b : b;
        cin = (ctl == 2'b01) ? 1'b1 : (adc & cf);
        s   = {1'b0, a} + {1'b0, be} + {32'b0, cin};
        v   = (a[31] == be[31]) && (s[31] != a[31]);
        return {s[31], (s[31:0] == 32'b0), s[32], v, s[31:0]};
    endfunction

    assign {flags_0, alur_0} = alu_f(srca_0, srcb_0, ctl_0, adc_0, cf_0);
    assign {flags_1, alur_1} = alu_f(srca_1, srcb_1, ctl_1, adc_1, cf_1);

    alu_mul_sequencer #(.WIDTH(32), .EARLY_TERM(1'b0)) u_dut (
        .CLK(clk), .RESET(rst), .Start(start0), .MCycleSigned(sgn),
        .Operand1(op1), .Operand2(op2), .Result1(r1_0), .Result2(r2_0),
        .Busy(busy_0), .Done(done_0), .ALU_SrcA(srca_0), .ALU_SrcB(srcb_0),
        .ALU_Control(ctl_0), .ALU_isADC(adc_0), .ALU_CFlag(cf_0), .ALU_isArith(arith_0),
        .ALUResult_in(alur_0), .ALUFlags_in(flags_0)
    );

    alu_mul_sequencer #(.WIDTH(32), .EARLY_TERM(1'b1)) u_dut_et (
        .CLK(clk), .RESET(rst), .Start(start1), .MCycleSigned(sgn),
        .Operand1(op1), .Operand2(op2), .Result1(r1_1), .Result2(r2_1),
        .Busy(busy_1), .Done(done_1), .ALU_SrcA(srca_1), .ALU_SrcB(srcb_1),
        .ALU_Control(ctl_1), .ALU_isADC(adc_1), .ALU_CFlag(cf_1), .ALU_isArith(arith_1),
        .ALUResult_in(alur_1), .ALUFlags_in(flags_1)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Launch one op, watch 45 cycles; optionally re-pulse Start in cycle restart_cyc.
    task automatic run_op(input string tag, input bit et, input bit s,
                          input logic [31:0] a, input logic [31:0] b,
                          input int exp_lat, input logic [63:0] exp_p, input int restart_cyc);
        int          lat;
        int          ndone;
        logic [63:0] got;
        lat   = -1;
        ndone = 0;
        got   = '0;
        @(negedge clk);
        sgn = s;
        op1 = a;
        op2 = b;
        if (et) start1 = 1'b1;
        else    start0 = 1'b1;
        for (int k = 1; k <= 45; k++) begin
            @(negedge clk);
            start0 = 1'b0;
            start1 = 1'b0;
            op1    = 32'hA5A5_5A5A;
            op2    = 32'h5A5A_A5A5;
            sgn    = ~s;
            if (k == restart_cyc) begin
                op1 = 32'd3;
                op2 = 32'd3;
                sgn = 1'b0;
                if (et) start1 = 1'b1;
                else    start0 = 1'b1;
            end
            if (k == 1) chk({tag, " busy_c1"}, {63'b0, et ? busy_1 : busy_0}, 64'd1);
            if (et ? done_1 : done_0) begin
                ndone++;
                if (lat < 0) begin
                    lat = k;
                    got = et ? {r2_1, r1_1} : {r2_0, r1_0};
                    chk({tag, " busy_at_done"}, {63'b0, et ? busy_1 : busy_0}, 64'd1);
                end
            end
        end
        chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
        chk({tag, " product"}, got, exp_p);
        chk({tag, " held"}, et ? {r2_1, r1_1} : {r2_0, r1_0}, exp_p);
        chk({tag, " done_count"}, 64'(ndone), 64'd1);
        chk({tag, " idle_busy"}, {63'b0, et ? busy_1 : busy_0}, 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int nd;
        repeat (3) @(negedge clk);
        chk("rst result", {r2_0, r1_0}, 64'd0);
        chk("rst busy_done", {62'b0, busy_0, done_0}, 64'd0);
        chk("rst alu", {srca_0, srcb_0}, 64'd0);
        chk("rst alu_ctl", {59'b0, ctl_0, adc_0, cf_0, arith_0}, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle alu_arith", {63'b0, arith_0}, 64'd0);

        run_op("u7x6",     1'b0, 1'b0, 32'd7,          32'd6,          33, 64'h0000_0000_0000_002A, 0);
        run_op("uffxff",   1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 64'hFFFF_FFFE_0000_0001, 0);
        run_op("s-3x5",    1'b0, 1'b1, 32'hFFFF_FFFD, 32'd5,          37, 64'hFFFF_FFFF_FFFF_FFF1, 0);
        run_op("s8x8",     1'b0, 1'b1, 32'h8000_0000, 32'h8000_0000, 35, 64'h4000_0000_0000_0000, 0);
        run_op("s0x-1",    1'b0, 1'b1, 32'd0,          32'hFFFF_FFFF, 37, 64'h0000_0000_0000_0000, 0);
        run_op("s-1x-1",   1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 35, 64'h0000_0000_0000_0001, 0);
        run_op("busy_start", 1'b0, 1'b0, 32'd7,        32'd6,          33, 64'h0000_0000_0000_002A, 10);
        run_op("done_start", 1'b0, 1'b0, 32'h0001_0000, 32'h0001_0000, 33, 64'h0000_0001_0000_0000, 33);
        run_op("et_u5x3",  1'b1, 1'b0, 32'd5,          32'd3,          3,  64'h0000_0000_0000_000F, 0);
        run_op("et_s-5x3", 1'b1, 1'b1, 32'hFFFF_FFFB, 32'd3,          7,  64'hFFFF_FFFF_FFFF_FFF1, 0);
        run_op("et_uffxff", 1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 64'hFFFF_FFFE_0000_0001, 0);

        // Asynchronous reset in the middle of an operation.
        @(negedge clk);
        op1    = 32'd9;
        op2    = 32'd9;
        sgn    = 1'b0;
        start0 = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            start0 = 1'b0;
        end
        chk("mid busy", {63'b0, busy_0}, 64'd1);
        rst = 1'b1;
        #1;
        chk("midrst busy", {63'b0, busy_0}, 64'd0);
        chk("midrst result", {r2_0, r1_0}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        nd  = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done_0) nd++;
        end
        chk("midrst no_done", 64'(nd), 64'd0);
        chk("midrst result_hold", {r2_0, r1_0}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
